// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream multiplexer slice.
// Channel index types are parameter-dependent and live in the users.
package stream_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Fixed-priority or round-robin arbiter with an owned priority pointer.
// The grant is purely combinational; the pointer moves only on advance.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr;

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (ARB_MODE == ARB_RR) ? int'(ptr) + k : k;
            // Explicit wrap so non-power-of-two channel counts behave.
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && (ARB_MODE == ARB_RR)) begin
            if (grant_idx == CH_W'(NUM_CH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + CH_W'(1);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with a single registered output stage.
// in_ready is gated by reset and by the output stage being loadable.
module rr_stream_mux
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    logic              can_load;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              advance;
    logic [DATA_W-1:0] sel_data;

    assign can_load = !out_valid || out_ready;
    assign req      = (can_load && !rst) ? in_valid : '0;
    assign advance  = |grant;
    assign in_ready = grant;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE),
        .CH_W     (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = in_data[grant_idx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel, W-bit stream multiplexer that replaces the free-running 4:1 combinational mux in the datapath. Each channel presents data with a valid/ready handshake, and an internal arbiter (fixed-priority or round-robin) picks one requesting channel per cycle. The granted word is captured into a single output register together with its channel index. The block sits between several producer channels and one consumer port.

## Interface
- `NUM_CH`, 4: number of input channels, ≥2.
- `DATA_W`, 4: data width per channel, ≥1.
- `ARB_MODE`, 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `CH_W`, `$clog2(NUM_CH)`: channel index width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  NUM_CH  per-channel request.
- `in_data`  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- `in_ready`  out  NUM_CH  one-hot or zero; asserted for the granted channel.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  DATA_W  registered word.
- `out_ch`  out  CH_W  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.

## Operation
- Transfer on channel i occurs when `in_valid[i] && in_ready[i]`. Output transfer occurs when `out_valid && out_ready`.
- The output stage can load when `!out_valid || out_ready`.
- Grant is computed only when the stage can load and at least one `in_valid` bit is set. Exactly one `in_ready` bit rises, for the grant index g. Otherwise `in_ready` is all zero.
- On a granted cycle, at the clock edge:
  - `out_data` takes channel g's data.
  - `out_ch` takes g.
  - `out_valid` becomes 1.
- With the output accepted and no request pending: `out_valid` becomes 0, and `out_data`/`out_ch` hold their last value.
- Hold rule: while `out_valid && !out_ready`, `out_data`, `out_ch` and `out_valid` are stable and `in_ready` is all zero.
- `ARB_MODE=0`: g is the lowest set index of `in_valid`.
- `ARB_MODE=1`:
  - Priority pointer `ptr` (CH_W bits). g is the first set `in_valid` index scanning ptr, ptr+1, …, wrapping modulo NUM_CH.
  - After each grant, `ptr` becomes (g+1) mod NUM_CH. Wrap from NUM_CH-1 goes to 0; for non-power-of-two NUM_CH, wrap is explicit and not by overflow.
  - `ptr` is unchanged on cycles with no grant.
- Producers must hold `in_valid` and `in_data` until accepted. The block does not itself depend on this.
- Simultaneous accept and reload: when `out_ready=1` and a request is pending in the same cycle, the new word loads at the edge. This gives back-to-back throughput of one word per cycle.

## Timing
- Reset (`rst=1` at an edge) forces:
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=0.
  - `in_ready` evaluates to 0 in the cycle `rst` is high; it is gated by `rst`.
- Reset mid-transfer discards the held word. No partial state survives.
- Latency: 1 cycle from input transfer to `out_valid`.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready`, `ptr` and `rst`. There is a combinational path `out_ready` → `in_ready`; this is documented and accepted.
- No combinational path from `in_data` to any output.

## Structure
- Shared package `stream_mux_pkg`:
  - `ARB_FIXED`=0 and `ARB_RR`=1 constants.
  - `ch_idx_t` is not typed there, since it is parameter-dependent; `CH_W` is computed locally.
- Sub-module `rr_arbiter`:
  - Parameters: `NUM_CH`, `ARB_MODE`.
  - Inputs: `clk`, `rst`, `req[NUM_CH]`, `advance`.
  - Outputs: `grant` (one-hot), `grant_idx`.
  - Owns `ptr`.
- The top level owns the output register and the data select.

## Test plan
All scenarios use NUM_CH=4 and DATA_W=4.

- **Reset:** hold `rst` for 2 cycles with all `in_valid`=1 → `in_ready`=0000, `out_valid`=0, `out_data`=0, `out_ch`=0 throughout.
- **Single channel:** `in_valid`=0100, channel 2 data=4'hA, `out_ready`=1 → `in_ready`=0100 in the cycle; next cycle `out_valid`=1, `out_data`=A, `out_ch`=2.
- **Round-robin fairness** (ARB_MODE=1): all four valid with data 1,2,3,4, `out_ready` tied 1 → `out_ch` sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- **Fixed priority** (ARB_MODE=0): `in_valid`=1010 held for 3 cycles → `out_ch`=1 every cycle; channel 3 never granted.
- **Backpressure:** `out_valid`=1 with `out_data`=5, `out_ready`=0 for 4 cycles, requests pending → `out_data`/`out_ch` stable and `in_ready`=0000. When `out_ready` rises, the pending grant loads on the next edge with no bubble.
- **Reset mid-operation:** assert `rst` while `out_valid`=1 and `ptr`=3 → next cycle `out_valid`=0. The first grant after reset, with all channels valid, goes to channel 0.
